fft_input_framer: RTL and testbench

- Streaming-to-frame front end that sits directly upstream of the N-point FFT core.
- Accepts complex samples one per cycle over a valid/ready handshake and assembles them into N-point frames, placing each sample at its bit-reversed slot.
- Holds each completed frame stable on flat parallel buses and drives the FFT's level start until the FFT reports done.
- Double-buffered (ping-pong), so one frame can fill while the other is being transformed.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_input_framer_if.sv | 25 ++
 rtl/fft_window_rom.sv | 18 +
 rtl/fft_input_framer.sv | 155 +++++++++++++++
 tb/tb_fft_input_framer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared parameters, output FSM encoding and helpers for the FFT input framer.
// hann_coef() is only referenced when FFT_INPUT_WINDOW_EN is defined.
package fft_pkg;

  localparam int N          = 8;
  localparam int DATA_WIDTH = 32;
  localparam int LOG2N      = 3;
  localparam int START_HOLD = 2;
  localparam int HOLD_W     = $clog2(START_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } fsm_state_e;

  // Reverses the low nbits of idx; the remaining upper bits come out zero.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx, input int nbits);
    logic [LOG2N-1:0] r;
    logic [LOG2N-1:0] src;
    r   = '0;
    src = idx;
    for (int b = 0; b < LOG2N; b++) begin
      if (b < nbits) begin
        r   = {r[LOG2N-2:0], src[0]};
        src = {1'b0, src[LOG2N-1:1]};
      end else begin
        r   = r;
        src = src;
      end
    end
    return r;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] hann_coef(input int k);
    real w;
    w = 0.5 - 0.5 * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
    return DATA_WIDTH'(longint'(w * (2.0 ** real'(DATA_WIDTH - 2))));
  endfunction

endpackage

// File: rtl/fft_input_framer_if.sv
// Sample stream, frame buses and FFT start/done handshake of the input framer.
interface fft_input_framer_if;
  import fft_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic signed [DATA_WIDTH-1:0]  in_real;
  logic signed [DATA_WIDTH-1:0]  in_imag;
  logic [N*DATA_WIDTH-1:0]       frame_real;
  logic [N*DATA_WIDTH-1:0]       frame_imag;
  logic                          fft_start;
  logic                          fft_done;
  logic [15:0]                   frames_issued;

  modport slave (
    input  in_valid, in_real, in_imag, fft_done,
    output in_ready, frame_real, frame_imag, fft_start, frames_issued
  );

  modport master (
    output in_valid, in_real, in_imag, fft_done,
    input  in_ready, frame_real, frame_imag, fft_start, frames_issued
  );

endinterface

// File: rtl/fft_window_rom.sv
// Constant periodic Hann coefficient table in Q2.(DATA_WIDTH-2), indexed by sample position.
module fft_window_rom
  import fft_pkg::*;
(
  input  logic [LOG2N-1:0]             idx,
  output logic signed [DATA_WIDTH-1:0] coef
);

  logic signed [DATA_WIDTH-1:0] coef_tab_s [N];

  for (genvar k = 0; k < N; k++) begin : g_coef
    localparam logic signed [DATA_WIDTH-1:0] COEF = hann_coef(k);
    assign coef_tab_s[k] = COEF;
  end

  assign coef = coef_tab_s[idx];

endmodule

// File: rtl/fft_input_framer.sv
// Ping-pong framer: bit-reversed frame assembly feeding an N-point FFT core.
// Optional Hann windowing on the write path is enabled by FFT_INPUT_WINDOW_EN.
module fft_input_framer
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fft_input_framer_if.slave  bus
);

  localparam int W = N * DATA_WIDTH;

  logic [W-1:0]                 bank_real_q [2];
  logic [W-1:0]                 bank_real_d [2];
  logic [W-1:0]                 bank_imag_q [2];
  logic [W-1:0]                 bank_imag_d [2];
  logic [1:0]                   bank_full_q, bank_full_d;
  logic [LOG2N-1:0]             wr_idx_q, wr_idx_d;
  logic                         wr_bank_q, wr_bank_d;
  logic                         rd_bank_q, rd_bank_d;
  fsm_state_e                   state_q, state_d;
  logic [HOLD_W-1:0]            hold_cnt_q, hold_cnt_d;
  logic [W-1:0]                 frame_real_q, frame_real_d;
  logic [W-1:0]                 frame_imag_q, frame_imag_d;
  logic                         fft_start_q, fft_start_d;
  logic [15:0]                  frames_issued_q, frames_issued_d;
  logic                         in_ready_q, in_ready_d;
  logic                         accept_s;
  logic signed [DATA_WIDTH-1:0] wr_real_s, wr_imag_s;

`ifdef FFT_INPUT_WINDOW_EN
  logic signed [DATA_WIDTH-1:0]   coef_s;
  logic signed [2*DATA_WIDTH-1:0] prod_real_s, prod_imag_s;

  fft_window_rom u_window_rom (
    .idx  (wr_idx_q),
    .coef (coef_s)
  );

  assign prod_real_s = bus.in_real * coef_s;
  assign prod_imag_s = bus.in_imag * coef_s;
  assign wr_real_s   = DATA_WIDTH'(prod_real_s >>> (DATA_WIDTH - 2));
  assign wr_imag_s   = DATA_WIDTH'(prod_imag_s >>> (DATA_WIDTH - 2));
`else
  assign wr_real_s = bus.in_real;
  assign wr_imag_s = bus.in_imag;
`endif

  // Next-state logic: write path, bank bookkeeping and the output FSM.
  always_comb begin
    bank_real_d     = bank_real_q;
    bank_imag_d     = bank_imag_q;
    bank_full_d     = bank_full_q;
    wr_idx_d        = wr_idx_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    frame_real_d    = frame_real_q;
    frame_imag_d    = frame_imag_q;
    fft_start_d     = fft_start_q;
    frames_issued_d = frames_issued_q;
    accept_s        = bus.in_valid && in_ready_q;

    if (accept_s) begin
      bank_real_d[wr_bank_q][bitrev(wr_idx_q, LOG2N)*DATA_WIDTH +: DATA_WIDTH] = wr_real_s;
      bank_imag_d[wr_bank_q][bitrev(wr_idx_q, LOG2N)*DATA_WIDTH +: DATA_WIDTH] = wr_imag_s;
      if (wr_idx_q == LOG2N'(N - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_idx_d               = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end

    // Banks fill and drain in strict alternation, so rd_bank is always the oldest full bank.
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        frame_real_d = bank_real_q[rd_bank_q];
        frame_imag_d = bank_imag_q[rd_bank_q];
        fft_start_d  = 1'b1;
        hold_cnt_d   = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        if ((hold_cnt_q >= HOLD_W'(START_HOLD)) && bus.fft_done) begin
          fft_start_d            = 1'b0;
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          frames_issued_d        = frames_issued_q + 16'd1;
          state_d                = IDLE;
        end else if (hold_cnt_q < HOLD_W'(START_HOLD)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = ~bank_full_d[wr_bank_d];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_real_q     <= '{default: '0};
      bank_imag_q     <= '{default: '0};
      bank_full_q     <= 2'b00;
      wr_idx_q        <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      state_q         <= IDLE;
      hold_cnt_q      <= '0;
      frame_real_q    <= '0;
      frame_imag_q    <= '0;
      fft_start_q     <= 1'b0;
      frames_issued_q <= 16'd0;
      in_ready_q      <= 1'b1;
    end else begin
      bank_real_q     <= bank_real_d;
      bank_imag_q     <= bank_imag_d;
      bank_full_q     <= bank_full_d;
      wr_idx_q        <= wr_idx_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      frame_real_q    <= frame_real_d;
      frame_imag_q    <= frame_imag_d;
      fft_start_q     <= fft_start_d;
      frames_issued_q <= frames_issued_d;
      in_ready_q      <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.frame_real    = frame_real_q;
  assign bus.frame_imag    = frame_imag_q;
  assign bus.fft_start     = fft_start_q;
  assign bus.frames_issued = frames_issued_q;

endmodule

// File: tb/tb_fft_input_framer.sv
// Randomized and directed bench for fft_input_framer against a frame-queue timing model.
module tb_fft_input_framer;
  import fft_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int W  = N * DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;

  fft_input_framer_if bus ();

  fft_input_framer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           c;
  } mframe_t;

  mframe_t      fq[$];
  logic [W-1:0] acc_re, acc_im;
  int           acc_n;
  int           edge_n;
  int           r_prev;
  bit           head_issued;
  int           head_s;
  logic         exp_ready, exp_start;
  logic [15:0]  exp_cnt;
  logic [W-1:0] exp_fre, exp_fim;
  int           pass_n, total_n;

  function automatic int brev(input int k);
    int r, v;
    r = 0;
    v = k;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

`ifdef FFT_INPUT_WINDOW_EN
  function automatic logic [DW-1:0] win(input logic [DW-1:0] x, input int k);
    real w;
    longint c;
    logic signed [DW-1:0]   cs;
    logic signed [2*DW-1:0] p;
    w  = 0.5 - 0.5 * $cos(2.0 * 3.14159265358979323846 * k / N);
    c  = longint'(w * (2.0 ** (DW - 2)));
    cs = c[DW-1:0];
    p  = $signed(x) * cs;
    return DW'(p >>> (DW - 2));
  endfunction
`endif

  task automatic model_reset();
    fq.delete();
    acc_re      = '0;
    acc_im      = '0;
    acc_n       = 0;
    r_prev      = -100;
    head_issued = 1'b0;
    head_s      = 0;
    exp_ready   = 1'b1;
    exp_start   = 1'b0;
    exp_cnt     = 16'd0;
    exp_fre     = '0;
    exp_fim     = '0;
  endtask

  task automatic model_edge(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                            input logic done, input logic r);
    logic acc;
    int   slot, m;
    logic [DW-1:0] wre, wim;
    edge_n++;
    if (r) begin
      model_reset();
      return;
    end
    acc = v && exp_ready;
    if (head_issued && done && edge_n >= head_s + START_HOLD + 1) begin
      void'(fq.pop_front());
      head_issued = 1'b0;
      exp_start   = 1'b0;
      exp_cnt     = exp_cnt + 16'd1;
      r_prev      = edge_n;
    end
    if (acc) begin
`ifdef FFT_INPUT_WINDOW_EN
      wre = win(re, acc_n);
      wim = win(im, acc_n);
`else
      wre = re;
      wim = im;
`endif
      slot = brev(acc_n);
      acc_re[slot*DW +: DW] = wre;
      acc_im[slot*DW +: DW] = wim;
      acc_n++;
      if (acc_n == N) begin
        fq.push_back('{acc_re, acc_im, edge_n});
        acc_n = 0;
      end
    end
    if (fq.size() > 0 && !head_issued) begin
      m = (fq[0].c > r_prev) ? fq[0].c : r_prev;
      if (edge_n == m + 2) begin
        head_issued = 1'b1;
        head_s      = edge_n;
        exp_start   = 1'b1;
        exp_fre     = fq[0].re;
        exp_fim     = fq[0].im;
      end
    end
    exp_ready = (fq.size() < 2);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total_n++;
    if (act === expv) pass_n++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, edge_n);
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    total_n++;
    if (act == expv) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
  endtask

  task automatic compare();
    chk("in_ready", W'(bus.in_ready), W'(exp_ready));
    chk("fft_start", W'(bus.fft_start), W'(exp_start));
    chk("frames_issued", W'(bus.frames_issued), W'(exp_cnt));
    chk("frame_real", bus.frame_real, exp_fre);
    chk("frame_imag", bus.frame_imag, exp_fim);
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                       input logic done, input logic r);
    bus.in_valid = v;
    bus.in_real  = re;
    bus.in_imag  = im;
    bus.fft_done = done;
    rst          = r;
    @(posedge clk);
    model_edge(v, re, im, done, r);
    @(negedge clk);
    compare();
  endtask

  int run_len, runs;

  task automatic track_start();
    if (bus.fft_start) begin
      run_len++;
    end else if (run_len > 0) begin
      chk_int("start_width", run_len, START_HOLD + 1);
      runs++;
      run_len = 0;
    end
  endtask

  int   lit [8] = '{10, 14, 12, 16, 11, 15, 13, 17};
  int   last_edge, rise, n_acc, acc_at_fall;
  logic done_r;

  initial begin
    pass_n  = 0;
    total_n = 0;
    edge_n  = 0;
    model_reset();
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    bus.fft_done = 1'b0;
    rst          = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk_int("reset_ready", int'(bus.in_ready), 1);

    // Bit-reversed assembly and start latency.
    for (int k = 0; k < 8; k++) cycle(1'b1, DW'(10 + k), '0, 1'b0, 1'b0);
    last_edge = edge_n;
    rise = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      if (rise < 0 && bus.fft_start) rise = edge_n;
    end
    chk_int("start_latency", rise - last_edge, 2);
`ifndef FFT_INPUT_WINDOW_EN
    for (int s = 0; s < 8; s++) chk_int("slot_real", int'(bus.frame_real[s*DW +: DW]), lit[s]);
`endif
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Backpressure with fft_done held low.
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    n_acc = 0;
    acc_at_fall = -1;
    for (int i = 0; i < 24; i++) begin
      if (bus.in_ready) n_acc++;
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
      if (acc_at_fall < 0 && !bus.in_ready) acc_at_fall = n_acc;
    end
    chk_int("accepts_before_backpressure", acc_at_fall, 16);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk_int("ready_after_release", int'(bus.in_ready), 1);
    chk_int("issued_after_release", int'(bus.frames_issued), 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk_int("second_frame_start", int'(bus.fft_start), 1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Sticky done: each frame holds start for START_HOLD+1 cycles.
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    run_len = 0;
    runs    = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
      track_start();
    end
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      track_start();
    end
    chk_int("sticky_frames", runs, 3);
    chk_int("sticky_count", int'(bus.frames_issued), 3);

    // Reset in the middle of a fill.
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk_int("rst_ready", int'(bus.in_ready), 1);
    chk_int("rst_start", int'(bus.fft_start), 0);
    chk_int("rst_count", int'(bus.frames_issued), 0);
    chk_int("rst_frame_zero", int'(bus.frame_real == '0), 1);
    for (int k = 0; k < 8; k++) cycle(1'b1, DW'(100 + k), DW'(200 + k), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
`ifndef FFT_INPUT_WINDOW_EN
    chk_int("rst_slot0_real", int'(bus.frame_real[0 +: DW]), 100);
    chk_int("rst_slot1_real", int'(bus.frame_real[DW +: DW]), 104);
    chk_int("rst_slot0_imag", int'(bus.frame_imag[0 +: DW]), 200);
`endif
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef FFT_INPUT_WINDOW_EN
    // Hann window on a constant input.
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b1, DW'(1000), DW'(1000), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk_int("win_slot0", int'(bus.frame_real[0 +: DW]), 0);
    chk_int("win_slot1", int'(bus.frame_real[DW +: DW]), 1000);
    chk_int("win_slot2", int'(bus.frame_real[2*DW +: DW]), 500);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
`endif

    // Randomized traffic with wandering fft_done and rare resets.
    done_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) done_r = ~done_r;
      cycle($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom), done_r,
            $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
